// File: rtl/j11_mem_resp.sv
// rtl/j11_mem_resp.sv - wait-stated 16-bit memory responder; optional NXM detection via J11_MEM_RESP_NXM_EN
module j11_mem_resp #(
  parameter int WAIT   = 2,
  parameter int AWIDTH = 12
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        memreq,
  input  logic        memwr,
  input  logic [21:0] memaddr,
  input  logic [15:0] memwdata,
  output logic        memack,
  output logic [15:0] memrdata,
  output logic        memnxm
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [AWIDTH-1:0]   idx_q, idx_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                nxm_q, nxm_d;
  logic                memack_q, memack_d;
  logic                memnxm_q, memnxm_d;
  logic [15:0]         memrdata_q, memrdata_d;
  logic                ram_we;
  logic                req_nxm;
  logic                unused_addr;
  logic [15:0]         ram [2**AWIDTH];

`ifdef J11_MEM_RESP_NXM_EN
  assign req_nxm     = |memaddr[21:AWIDTH+1];
  assign unused_addr = memaddr[0];
`else
  // Upper address bits alias onto the RAM when NXM detection is off.
  assign req_nxm     = 1'b0;
  assign unused_addr = ^{memaddr[21:AWIDTH+1], memaddr[0]};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    nxm_d      = nxm_q;
    memrdata_d = memrdata_q;
    ram_we     = 1'b0;
    // The ack pulse is registered off the ACK state, so it lands in the first IDLE cycle.
    memack_d   = (state_q == ACK);
    memnxm_d   = (state_q == ACK) && nxm_q;
    case (state_q)
      IDLE: begin
        if (memreq) begin
          state_d = BUSY;
          cnt_d   = 4'(WAIT);
          wr_d    = memwr;
          idx_d   = memaddr[AWIDTH:1];
          wdata_d = memwdata;
          nxm_d   = req_nxm;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ACK;
          if (wr_q) begin
            ram_we = !nxm_q;
          end else begin
            memrdata_d = nxm_q ? 16'h0000 : ram[idx_q];
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 16'h0000;
      nxm_q      <= 1'b0;
      memack_q   <= 1'b0;
      memnxm_q   <= 1'b0;
      memrdata_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      nxm_q      <= nxm_d;
      memack_q   <= memack_d;
      memnxm_q   <= memnxm_d;
      memrdata_q <= memrdata_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[idx_q] <= wdata_q;
  end

  assign memack   = memack_q;
  assign memnxm   = memnxm_q;
  assign memrdata = memrdata_q;

endmodule

// File: doc/j11_mem_resp.md
J11_MEM_RESP -- requirements
Module: j11_mem_resp

Interface
REQ-001 The block SHALL have parameter WAIT, default 2, meaning the number of extra wait-state cycles inserted before each access completes (range 0-15).
REQ-002 The block SHALL have parameter AWIDTH, default 12, meaning the number of word-address bits of the internal RAM (2**AWIDTH 16-bit words).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 memreq  input  1  access request; held with memwr/memaddr/memwdata stable until memack.
REQ-006 memwr  input  1  1 = write, 0 = read.
REQ-007 memaddr  input  22  byte address; bit 0 ignored, word index = memaddr[AWIDTH:1].
REQ-008 memwdata  input  16  write data.
REQ-009 memack  output  1  single-cycle completion pulse.
REQ-010 memrdata  output  16  read data, valid in the memack cycle of a read.
REQ-011 memnxm  output  1  nonexistent-memory flag, valid only in the memack cycle.

Function
REQ-012 The block SHALL implement states IDLE, BUSY and ACK.
REQ-013 In IDLE, with memreq=1 at an edge, the block SHALL capture memwr, memaddr and memwdata, load the wait counter with WAIT, and enter BUSY; with memreq=0 it SHALL stay in IDLE.
REQ-014 In BUSY with counter != 0, the block SHALL decrement the counter each edge and stay in BUSY.
REQ-015 In BUSY with counter == 0, the block SHALL perform the RAM operation at that edge and enter ACK:
  - write: RAM[index] <= captured wdata;
  - read: memrdata <= RAM[index].
REQ-016 In ACK, memack SHALL be 1 for exactly one cycle, after which the block SHALL return to IDLE; memreq is not sampled while in ACK.
REQ-017 Latency SHALL be: memreq sampled at edge N gives memack high in the cycle after edge N+WAIT+2.
REQ-018 Back-to-back access: a memreq still high in the first IDLE cycle after ACK SHALL be accepted as a new access, so each access occupies at least WAIT+3 cycles.
REQ-019 memrdata SHALL hold its last read value until the next read completes; writes SHALL NOT change it.
REQ-020 Changes on memreq, memwr, memaddr or memwdata during BUSY or ACK SHALL have no effect on the access in progress.
REQ-021 memack SHALL be a registered output with no combinational path from any input.

Reset
REQ-022 rstn=0 SHALL immediately force state IDLE, counter 0, memack 0, memnxm 0 and memrdata 16'h0000.
REQ-023 Reset mid-access SHALL abandon the access: no ack, and no RAM write unless the write edge had already occurred.
REQ-024 Reset SHALL NOT clear RAM contents.
REQ-025 On rstn deassertion the block SHALL accept a new request at the first edge.

Configuration
REQ-026 With macro J11_MEM_RESP_NXM_EN defined, an access whose memaddr[21:AWIDTH+1] is non-zero SHALL:
  - still complete with normal latency and memack;
  - assert memnxm=1 in the ack cycle;
  - perform no RAM write;
  - return memrdata=16'h0000 for reads.
REQ-027 Without J11_MEM_RESP_NXM_EN, memaddr[21:AWIDTH+1] SHALL be ignored (addresses alias) and memnxm SHALL be tied to 0.

Verification
REQ-028 Write, then read: WAIT=2, write 16'o123456 to memaddr 22'o000100, then read 22'o000100 -> each memack arrives 4 cycles after its request is sampled, and the read returns 16'o123456.
REQ-029 Odd address: write 16'h00FF to address 22'h000003, read 22'h000002 -> read returns 16'h00FF.
REQ-030 Back-to-back: WAIT=0, memreq held high for 3 reads -> memack pulses every 3 cycles, each exactly 1 cycle wide.
REQ-031 Reset mid-access: rstn pulsed low during BUSY of a write of 16'hBEEF to 22'h000010 -> no memack; a later read of 22'h000010 returns the prior contents; memrdata = 0 after reset.
REQ-032 NXM with J11_MEM_RESP_NXM_EN: write 16'h1234 to 22'h200000, then read 22'h000000 -> write acks with memnxm=1, and word 0 is unchanged.
REQ-033 NXM without J11_MEM_RESP_NXM_EN: the same stimulus as REQ-032 -> word 0 reads 16'h1234 and memnxm stays 0.
